// File: rtl/axis_route_queue.sv
// Per-input ingress stage: buffers one AXI-Stream input in a small FIFO and
// holds an XY route (one-hot selector) for the packet at the head until its TLAST leaves.
module axis_route_queue #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned DEST_WIDTH         = 4,
    parameter int unsigned CHANNEL_NUMBER_OUT = 5,
    parameter int unsigned DEPTH              = 4,
    parameter logic [DEST_WIDTH/2-1:0] ROUTER_X = '0,
    parameter logic [DEST_WIDTH/2-1:0] ROUTER_Y = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         in_tdata_i,
    input  logic                          in_tvalid_i,
    output logic                          in_tready_o,
    input  logic                          in_tlast_i,
    input  logic [DEST_WIDTH-1:0]         in_tdest_i,
    output logic [DATA_WIDTH-1:0]         out_tdata_o,
    output logic                          out_tvalid_o,
    input  logic                          out_tready_i,
    output logic                          out_tlast_o,
    output logic [DEST_WIDTH-1:0]         out_tdest_o,
    output logic [CHANNEL_NUMBER_OUT-1:0] selector_o
);

    localparam int unsigned HALF    = DEST_WIDTH / 2;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = DATA_WIDTH + 1 + DEST_WIDTH;

    typedef enum logic {S_HEAD, S_ROUTED} state_t;

    state_t                          state_q, state_d;
    logic [CHANNEL_NUMBER_OUT-1:0]   selector_q, selector_d;
    logic [PTR_W-1:0]                wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]                count_q;
    logic [ENTRY_W-1:0]              mem_q [DEPTH];

    logic                  wr_en, rd_en, empty;
    logic [ENTRY_W-1:0]    head;
    logic                  head_last;
    logic [DEST_WIDTH-1:0] head_dest;

    // X is resolved before Y; unsigned compares against this router's coordinates.
    function automatic logic [CHANNEL_NUMBER_OUT-1:0] route(input logic [DEST_WIDTH-1:0] dest);
        logic [HALF-1:0] dx, dy;
        route = '0;
        dx    = dest[HALF-1:0];
        dy    = dest[DEST_WIDTH-1:HALF];
        if (dx > ROUTER_X)      route[2] = 1'b1;
        else if (dx < ROUTER_X) route[4] = 1'b1;
        else if (dy < ROUTER_Y) route[1] = 1'b1;
        else if (dy > ROUTER_Y) route[3] = 1'b1;
        else                    route[0] = 1'b1;
    endfunction

    assign empty       = (count_q == '0);
    assign in_tready_o = !rst && (count_q < CNT_W'(DEPTH));
    assign wr_en       = in_tvalid_i && in_tready_o;
    assign rd_en       = out_tvalid_o && out_tready_i;
    assign head        = mem_q[rd_ptr_q];
    assign head_dest   = head[DEST_WIDTH-1:0];
    assign head_last   = head[DEST_WIDTH];
    assign selector_o  = selector_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {in_tdata_i, in_tlast_i, in_tdest_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HEAD;
            selector_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            selector_q <= selector_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (wr_en && !rd_en)      count_q <= count_q + CNT_W'(1);
            else if (rd_en && !wr_en) count_q <= count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        selector_d = selector_q;
        unique case (state_q)
            S_HEAD: begin
                if (!empty) begin
                    state_d    = S_ROUTED;
                    selector_d = route(head_dest);
                end
            end
            S_ROUTED: begin
                if (rd_en && head_last) begin
                    state_d    = S_HEAD;
                    selector_d = '0;
                end
            end
            default: begin
                state_d    = S_HEAD;
                selector_d = '0;
            end
        endcase
    end

    always_comb begin
        out_tvalid_o = (state_q == S_ROUTED) && !empty;
        out_tdata_o  = head[ENTRY_W-1:DEST_WIDTH+1];
        out_tlast_o  = head_last;
        out_tdest_o  = head_dest;
    end

endmodule

// File: tb/tb_axis_route_queue.sv
// Scoreboard bench for axis_route_queue at router (1,1), DEPTH 4: stimulus pushes
// expected beats (with expected selector), a monitor pops them as the DUT emits.
module tb_axis_route_queue;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  dest;
        logic [4:0]  sel;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic        in_tlast;
    logic [3:0]  in_tdest;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic [3:0]  out_tdest;
    logic [4:0]  selector;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    localparam logic [4:0] LOC = 5'b00001, NTH = 5'b00010, EST = 5'b00100,
                           STH = 5'b01000, WST = 5'b10000;
    // Hand-derived routes at (1,1): dx = tdest[1:0], dy = tdest[3:2]
    logic [4:0] sweep_tbl [16] = '{WST, NTH, EST, EST, WST, LOC, EST, EST,
                                   WST, STH, EST, EST, WST, STH, EST, EST};

    always #5 clk = ~clk;

    axis_route_queue #(
        .DATA_WIDTH(32), .DEST_WIDTH(4), .CHANNEL_NUMBER_OUT(5), .DEPTH(4),
        .ROUTER_X(2'd1), .ROUTER_Y(2'd1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_tdata_i(in_tdata), .in_tvalid_i(in_tvalid), .in_tready_o(in_tready),
        .in_tlast_i(in_tlast), .in_tdest_i(in_tdest),
        .out_tdata_o(out_tdata), .out_tvalid_o(out_tvalid), .out_tready_i(out_tready),
        .out_tlast_o(out_tlast), .out_tdest_o(out_tdest), .selector_o(selector)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [3:0] t, input logic [4:0] s);
        bit    ok = 1'b0;
        beat_t b;
        in_tdata  = d;
        in_tlast  = l;
        in_tdest  = t;
        in_tvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            ok = in_tready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_tvalid = 1'b0;
        if (ok) begin
            b = {d, l, t, s};
            exp_q.push_back(b);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: data %0h never accepted", d);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_tvalid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every transferred beat; after a TLAST beat the next cycle must be idle.
    initial begin
        bit    expect_idle = 1'b0;
        beat_t e, a;
        forever begin
            @(negedge clk);
            if (rst) begin
                expect_idle = 1'b0;
            end else begin
                if (expect_idle) begin
                    check("sel_gap", 64'(selector), 64'(0));
                    check("vld_gap", 64'(out_tvalid), 64'(0));
                    expect_idle = 1'b0;
                end
                if (out_tvalid && out_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h expected none", out_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        a = {out_tdata, out_tlast, out_tdest, selector};
                        check("beat", 64'(a), 64'(e));
                        if (e.last) expect_idle = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  accepted;
        int  idx;
        bit  ok;

        rst = 1'b1; in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0; in_tdest = '0;
        out_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tready", 64'(in_tready), 64'(0));
        check("rst_tvalid", 64'(out_tvalid), 64'(0));
        check("rst_sel", 64'(selector), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_rst", 64'(in_tready), 64'(1));
        @(posedge clk); #1;

        // 3-beat packet to dx=3, dy=0: east, with head latency checks
        out_tready = 1'b1;
        send(32'hA0, 1'b0, 4'h3, EST);
        @(negedge clk);
        check("lat_t1_sel", 64'(selector), 64'(0));
        check("lat_t1_vld", 64'(out_tvalid), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_t2_sel", 64'(selector), 64'(EST));
        check("lat_t2_vld", 64'(out_tvalid), 64'(1));
        @(posedge clk); #1;
        send(32'hA1, 1'b0, 4'h3, EST);
        send(32'hA2, 1'b1, 4'h3, EST);
        drain();
        check("sel_after_pkt", 64'(selector), 64'(0));

        // Route sweep over all destinations as single-beat packets
        for (int i = 0; i < 16; i++) send(32'h100 + i, 1'b1, 4'(i), sweep_tbl[i]);
        drain();

        // Fill with sink stalled: only DEPTH beats accepted
        out_tready = 1'b0;
        accepted = 0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_tdata = 32'h200 + idx; in_tlast = (idx == 5); in_tdest = 4'h2; in_tvalid = 1'b1;
            @(negedge clk);
            ok = in_tready;
            @(posedge clk); #1;
            if (ok) begin
                exp_q.push_back({32'h200 + idx, 1'b0, 4'h2, EST});
                idx++;
                accepted++;
            end
        end
        in_tvalid = 1'b0;
        check("full_accepted", 64'(accepted), 64'(4));
        @(negedge clk);
        check("full_tready", 64'(in_tready), 64'(0));
        check("full_sel", 64'(selector), 64'(EST));
        @(posedge clk); #1;
        out_tready = 1'b1;
        @(negedge clk);
        check("tready_before_read", 64'(in_tready), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("tready_after_read", 64'(in_tready), 64'(1));
        @(posedge clk); #1;
        send(32'h204, 1'b0, 4'h2, EST);
        send(32'h205, 1'b1, 4'h2, EST);
        drain();

        // Back-to-back single-beat packets: west then east
        send(32'h300, 1'b1, 4'h0, WST);
        send(32'h301, 1'b1, 4'hF, EST);
        drain();

        // Body beats carry other tdest values; route must not change
        send(32'h400, 1'b0, 4'h2, EST);
        send(32'h401, 1'b0, 4'h0, EST);
        send(32'h402, 1'b1, 4'h5, EST);
        drain();

        // Reset mid-packet drops the partial packet
        out_tready = 1'b0;
        send(32'h500, 1'b0, 4'h6, EST);
        send(32'h501, 1'b0, 4'h6, EST);
        repeat (2) @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_sel", 64'(selector), 64'(EST));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tready", 64'(in_tready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_rst_vld", 64'(out_tvalid), 64'(0));
        check("post_rst_sel", 64'(selector), 64'(0));
        check("post_rst_tready", 64'(in_tready), 64'(1));
        @(posedge clk); #1;
        out_tready = 1'b1;
        send(32'h600, 1'b0, 4'h9, STH);
        send(32'h601, 1'b1, 4'h9, STH);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
